// File: rtl/wb_arbiter_two_masters.sv
// Two-master to one-slave Wishbone classic arbiter (32-bit).
//
// A master holds the grant for its whole bus cycle (cyc high), with no
// preemption. Simultaneous requests from idle are resolved round-robin. When
// the owner drops cyc while the other master is requesting, the grant passes
// over directly with no idle cycle. The slave interrupt goes to both masters.
//
// Ports:
//   clk, rst          system clock; synchronous active-high reset
//   m0_*_i / m0_*_o   master 0 request bus in, read data/ack/interrupt out
//   m1_*_i / m1_*_o   master 1, same set
//   s_*_o / s_*_i     slave request bus out, read data/ack/interrupt in
module wb_arbiter_two_masters (
  input  logic        clk,
  input  logic        rst,
  // Master 0
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_int_o,
  // Master 1
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_int_o,
  // Slave
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_int_i
);

  localparam int unsigned DataWidth = 32;

  typedef enum logic [1:0] {OwnNone, OwnM0, OwnM1} owner_e;

  owner_e owner_q, owner_d;
  // Most recently granted master: 0 = M0, 1 = M1.
  logic   last_q, last_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OwnNone;
      last_q  <= 1'b1;  // M0 wins the first contention
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    owner_d = owner_q;
    last_d  = last_q;
    unique case (owner_q)
      OwnNone: begin
        if (m0_cyc_i && m1_cyc_i) begin
          owner_d = last_q ? OwnM0 : OwnM1;
        end else if (m0_cyc_i) begin
          owner_d = OwnM0;
        end else if (m1_cyc_i) begin
          owner_d = OwnM1;
        end
      end
      OwnM0: begin
        if (!m0_cyc_i) owner_d = m1_cyc_i ? OwnM1 : OwnNone;
      end
      OwnM1: begin
        if (!m1_cyc_i) owner_d = m0_cyc_i ? OwnM0 : OwnNone;
      end
      default: owner_d = OwnNone;
    endcase
    // Only a fresh grant can change the owner to a master, so this tracks grants.
    if (owner_d == OwnM0) last_d = 1'b0;
    if (owner_d == OwnM1) last_d = 1'b1;
  end

  // Combinational datapath steered by the registered owner, so a dropping
  // cyc/stb from the owner reaches the slave in the same cycle.
  always_comb begin
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_sel_o  = '0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    unique case (owner_q)
      OwnM0: begin
        s_we_o   = m0_we_i;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_sel_o  = m0_sel_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i;
      end
      OwnM1: begin
        s_we_o   = m1_we_i;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_sel_o  = m1_sel_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i;
      end
      default: ;
    endcase
  end

  assign m0_int_o = s_int_i;
  assign m1_int_o = s_int_i;

  // Width sanity for the fixed bus width.
  logic [DataWidth-1:0] unused_width_ref;
  assign unused_width_ref = s_dat_i;

endmodule

// File: tb/tb_wb_arbiter_two_masters.sv
module tb_wb_arbiter_two_masters;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_we_i, m0_cyc_i, m0_stb_i;
  logic [3:0]  m0_sel_i;
  logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
  logic        m0_ack_o, m0_int_o;
  logic        m1_we_i, m1_cyc_i, m1_stb_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
  logic        m1_ack_o, m1_int_o;
  logic        s_we_o, s_cyc_o, s_stb_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic        s_ack_i, s_int_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arbiter_two_masters dut (
    .clk      (clk),
    .rst      (rst),
    .m0_we_i  (m0_we_i),
    .m0_cyc_i (m0_cyc_i),
    .m0_stb_i (m0_stb_i),
    .m0_sel_i (m0_sel_i),
    .m0_adr_i (m0_adr_i),
    .m0_dat_i (m0_dat_i),
    .m0_dat_o (m0_dat_o),
    .m0_ack_o (m0_ack_o),
    .m0_int_o (m0_int_o),
    .m1_we_i  (m1_we_i),
    .m1_cyc_i (m1_cyc_i),
    .m1_stb_i (m1_stb_i),
    .m1_sel_i (m1_sel_i),
    .m1_adr_i (m1_adr_i),
    .m1_dat_i (m1_dat_i),
    .m1_dat_o (m1_dat_o),
    .m1_ack_o (m1_ack_o),
    .m1_int_o (m1_int_o),
    .s_we_o   (s_we_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_sel_o  (s_sel_o),
    .s_adr_o  (s_adr_o),
    .s_dat_o  (s_dat_o),
    .s_dat_i  (s_dat_i),
    .s_ack_i  (s_ack_i),
    .s_int_i  (s_int_i)
  );

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: who holds the bus (-1 none, 0 or 1) and who was granted last.
  int  mdl_owner = -1;
  int  mdl_last  = 1;
  bit  started   = 1'b0;

  always @(posedge clk) begin
    int nxt;
    if (rst) begin
      mdl_owner = -1;
      mdl_last  = 1;
      started   = 1'b1;
    end else begin
      nxt = mdl_owner;
      if (mdl_owner == -1) begin
        if (m0_cyc_i && m1_cyc_i) nxt = 1 - mdl_last;
        else if (m0_cyc_i)        nxt = 0;
        else if (m1_cyc_i)        nxt = 1;
      end else if (mdl_owner == 0 && !m0_cyc_i) begin
        nxt = m1_cyc_i ? 1 : -1;
      end else if (mdl_owner == 1 && !m1_cyc_i) begin
        nxt = m0_cyc_i ? 0 : -1;
      end
      if (nxt != -1 && nxt != mdl_owner) mdl_last = nxt;
      mdl_owner = nxt;
    end
  end

  // Every-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    logic [72:0] exp_s, got_s;
    logic [32:0] exp_m0, exp_m1;
    if (started) begin
      exp_s = '0;
      if (mdl_owner == 0) exp_s = {m0_we_i, m0_cyc_i, m0_stb_i, m0_sel_i, m0_adr_i, m0_dat_i};
      if (mdl_owner == 1) exp_s = {m1_we_i, m1_cyc_i, m1_stb_i, m1_sel_i, m1_adr_i, m1_dat_i};
      got_s  = {s_we_o, s_cyc_o, s_stb_o, s_sel_o, s_adr_o, s_dat_o};
      exp_m0 = (mdl_owner == 0) ? {s_ack_i, s_dat_i} : 33'd0;
      exp_m1 = (mdl_owner == 1) ? {s_ack_i, s_dat_i} : 33'd0;
      chk("slave_bus", 128'(got_s), 128'(exp_s));
      chk("m0_resp", 128'({m0_ack_o, m0_dat_o}), 128'(exp_m0));
      chk("m1_resp", 128'({m1_ack_o, m1_dat_o}), 128'(exp_m1));
      chk("irq", 128'({m0_int_o, m1_int_o}), 128'({s_int_i, s_int_i}));
    end
  end

  // Advance to just after the next rising edge(s).
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_masters();
    m0_we_i = 0; m0_cyc_i = 0; m0_stb_i = 0; m0_sel_i = 0; m0_adr_i = 0; m0_dat_i = 0;
    m1_we_i = 0; m1_cyc_i = 0; m1_stb_i = 0; m1_sel_i = 0; m1_adr_i = 0; m1_dat_i = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle_masters();
    s_dat_i = '0; s_ack_i = 1'b0; s_int_i = 1'b0;
    step(2);
    rst = 1'b0;
    chk("model_reset_owner", 128'(mdl_owner + 1), 128'd0);

    // Idle bus for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_cyc", 128'({s_cyc_o, m0_ack_o, m1_ack_o}), 128'd0);
      chk("idle_adr", 128'(s_adr_o), 128'd0);
    end
    step(1);

    // M0 write.
    m0_adr_i = 32'h10; m0_dat_i = 32'hDEADBEEF; m0_sel_i = 4'hF;
    m0_we_i = 1; m0_cyc_i = 1; m0_stb_i = 1;
    @(negedge clk);
    chk("grant_latency", 128'(s_cyc_o), 128'd0);
    step(1);
    s_ack_i = 1'b1;
    @(negedge clk);
    chk("m0_wr_adr", 128'(s_adr_o), 128'h10);
    chk("m0_wr_dat", 128'(s_dat_o), 128'hDEADBEEF);
    chk("m0_wr_we_cyc", 128'({s_we_o, s_cyc_o, s_stb_o, s_sel_o}), 128'h7F);
    chk("m0_wr_acks", 128'({m0_ack_o, m1_ack_o}), 128'b10);
    step(1);
    idle_masters(); s_ack_i = 1'b0;
    step(1);

    // M1 read.
    m1_adr_i = 32'h20; m1_sel_i = 4'hF; m1_cyc_i = 1; m1_stb_i = 1;
    step(1);
    s_dat_i = 32'h12345678; s_ack_i = 1'b1;
    @(negedge clk);
    chk("m1_rd_adr", 128'(s_adr_o), 128'h20);
    chk("m1_rd_dat", 128'({m1_ack_o, m1_dat_o}), 128'h1_12345678);
    chk("m1_rd_m0_dat", 128'({m0_ack_o, m0_dat_o}), 128'd0);
    step(1);
    idle_masters(); s_ack_i = 1'b0; s_dat_i = '0;
    step(1);

    // Round-robin after reset.
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    m0_adr_i = 32'h100; m1_adr_i = 32'h200;
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    step(1);
    @(negedge clk);
    chk("rr_first_m0", 128'(s_adr_o), 128'h100);
    chk("model_rr_owner", 128'(mdl_owner), 128'd0);
    m0_cyc_i = 0; m0_stb_i = 0;
    step(1);
    @(negedge clk);
    chk("handoff_m1", 128'({s_cyc_o, s_adr_o}), 128'h1_00000200);
    m1_cyc_i = 0; m1_stb_i = 0;
    step(1);
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    step(1);
    @(negedge clk);
    chk("rr_second_m0", 128'(s_adr_o), 128'h100);

    // M0 burst while M1 waits.
    s_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("burst_acks", 128'({m0_ack_o, m1_ack_o}), 128'b10);
      step(1);
    end
    s_ack_i = 1'b0; m0_cyc_i = 0; m0_stb_i = 0;
    @(negedge clk);
    chk("owner_drop_same_cycle", 128'({s_cyc_o, s_stb_o}), 128'd0);
    step(1);
    s_ack_i = 1'b1;
    @(negedge clk);
    chk("m1_after_burst", 128'({m0_ack_o, m1_ack_o, s_adr_o}), 128'h1_00000200);
    step(1);
    idle_masters(); s_ack_i = 1'b0;
    step(2);

    // Interrupt broadcast and stray ack with no owner.
    s_int_i = 1'b1; s_ack_i = 1'b1;
    @(negedge clk);
    chk("irq_no_owner", 128'({m0_int_o, m1_int_o}), 128'b11);
    chk("stray_ack", 128'({m0_ack_o, m1_ack_o, s_cyc_o}), 128'd0);
    step(1);
    s_int_i = 1'b0; s_ack_i = 1'b0;

    // Reset in the middle of an M1 transfer.
    m1_adr_i = 32'h300; m1_cyc_i = 1; m1_stb_i = 1;
    step(1);
    @(negedge clk);
    chk("pre_rst_m1", 128'(s_cyc_o), 128'd1);
    step(1);
    rst = 1'b1; s_ack_i = 1'b1;
    step(1);
    @(negedge clk);
    chk("rst_mid_idle", 128'({s_cyc_o, m1_ack_o, m0_ack_o}), 128'd0);
    rst = 1'b0;
    idle_masters(); s_ack_i = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_two_masters.md
Name: wb_arbiter_two_masters

Overview:
- Two-master to one-slave Wishbone (classic, 32-bit) bus arbiter.
- Lets the main interconnect port and a secondary master (e.g. console frame-buffer DMA) share a single slave such as a block RAM.
- Grants one master at a time and holds the grant for the owner's whole cycle (cyc high).
- Uses round-robin on simultaneous requests and broadcasts the slave interrupt to both masters.

Parameters:
- DATA_WIDTH, 32, width of data and address buses. Fixed; not overridable in this revision.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- m0_we_i  input  1  master 0 write enable
- m0_cyc_i  input  1  master 0 bus cycle request
- m0_stb_i  input  1  master 0 strobe
- m0_sel_i  input  4  master 0 byte select
- m0_adr_i  input  32  master 0 address
- m0_dat_i  input  32  master 0 write data
- m0_dat_o  output  32  read data to master 0
- m0_ack_o  output  1  acknowledge to master 0
- m0_int_o  output  1  interrupt to master 0
- m1_we_i, m1_cyc_i, m1_stb_i, m1_sel_i, m1_adr_i, m1_dat_i, m1_dat_o, m1_ack_o, m1_int_o: identical set for master 1
- s_we_o  output  1  slave write enable
- s_cyc_o  output  1  slave cycle
- s_stb_o  output  1  slave strobe
- s_sel_o  output  4  slave byte select
- s_adr_o  output  32  slave address
- s_dat_o  output  32  slave write data
- s_dat_i  input  32  slave read data
- s_ack_i  input  1  slave acknowledge
- s_int_i  input  1  slave interrupt

Behaviour:
- State register `owner`: NONE, M0, M1. Register `last`: the most recently granted master.
- Reset (synchronous): owner=NONE, last=M1, so M0 wins the first contention.
- Reset outputs: all s_* outputs 0; m*_ack_o=0; m*_dat_o=0.
- Arbitration is evaluated on each rising edge.
  - owner=NONE: if only one master's cyc_i is high, grant it. If both are high, grant the master that is not `last`. Update `last` on each grant.
  - owner=Mx and mx_cyc_i still high: hold the grant, with no preemption regardless of the other master.
  - owner=Mx and mx_cyc_i low: if the other master's cyc_i is high, grant it directly (no idle cycle). Otherwise owner=NONE.
- Grant latency: 1 clock from cyc_i rising to s_cyc_o rising.
- Datapath is combinational from `owner`:
  - s_we/cyc/stb/sel/adr/dat_o = owner's inputs.
  - owner's ack_o = s_ack_i; owner's dat_o = s_dat_i.
  - Non-owner ack_o=0 and dat_o=0.
- owner=NONE: all s_* outputs driven 0.
- When the owner drops cyc_i, s_cyc_o and s_stb_o fall in that same cycle (combinational pass-through). No spurious slave access occurs.
- s_ack_i arriving while owner=NONE is ignored; no master sees it.
- Interrupt: m0_int_o = m1_int_o = s_int_i at all times, independent of grant.
- Reset asserted mid-transfer: at the next edge owner=NONE and the slave bus goes idle. In-flight ack is not forwarded afterward.
- Non-owner requests are simply stalled (ack held 0) until granted; no error/retry signalling.

Test Plan:
- Reset, then hold both cyc=0 -> s_cyc_o=0, s_adr_o=0, m0/m1 ack_o=0 for 10 cycles.
- M0 write only: adr=0x10, dat=0xDEADBEEF, sel=0xF, stb=cyc=1 -> next cycle s_adr_o=0x10, s_dat_o=0xDEADBEEF, s_we_o=1. Slave ack -> m0_ack_o=1, m1_ack_o=0.
- M1 read only, adr=0x20, slave returns 0x12345678 -> m1_dat_o=0x12345678 with m1_ack_o=1; m0_dat_o=0.
- Both raise cyc on the same edge after reset -> M0 granted. M0 drops cyc -> M1 granted on the next edge without idle. Next simultaneous request -> M0 (round-robin).
- M0 owns with a multi-cycle burst while M1 requests -> M1 never sees ack until M0 cyc=0.
- s_int_i=1 with owner=NONE -> m0_int_o=m1_int_o=1. Assert rst during an M1 transfer -> s_cyc_o=0 on the next cycle.
